// File: rtl/spi_sclk_engine_if.sv
// -----------------------------------------------------------------------------
// spi_sclk_engine_if
// Groups the control, configuration and strobe/handshake signals between the
// transaction controller (master) and the SCLK engine (slave).
//   en_i, start_i      : block enable and burst request
//   div_i, nbits_i     : half-period minus one and SCLK cycles per burst
//   cpol_i, cpha_i     : SPI mode select
//   SCLK_o             : registered serial clock
//   shift_o, sample_o  : one-cycle MOSI shift / MISO capture strobes
//   bit_idx_o          : sample strobes issued in the current burst
//   busy_o, done_o     : burst in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
interface spi_sclk_engine_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
);
  logic             en_i;
  logic             start_i;
  logic [DIV_W-1:0] div_i;
  logic [CNT_W-1:0] nbits_i;
  logic             cpol_i;
  logic             cpha_i;
  logic             SCLK_o;
  logic             shift_o;
  logic             sample_o;
  logic [CNT_W-1:0] bit_idx_o;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  en_i, start_i, div_i, nbits_i, cpol_i, cpha_i,
    output SCLK_o, shift_o, sample_o, bit_idx_o, busy_o, done_o
  );

  modport master (
    output en_i, start_i, div_i, nbits_i, cpol_i, cpha_i,
    input  SCLK_o, shift_o, sample_o, bit_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/spi_sclk_engine.sv
// -----------------------------------------------------------------------------
// spi_sclk_engine
// Programmable SPI serial-clock engine. Runs a burst of N SCLK cycles with a
// half-period of div+1 system clocks in any CPOL/CPHA mode, emitting
// single-cycle shift/sample strobes and a busy/done handshake.
//   clock_i  : system clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : spi_sclk_engine_if slave modport (config in, strobes out)
// -----------------------------------------------------------------------------
module spi_sclk_engine #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  spi_sclk_engine_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic [CNT_W-1:0] bidx_q, bidx_d;
  logic             sclk_q, sclk_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             done_q, done_d;

  // Burst configuration captured at accept; only consulted outside IDLE.
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] nbits_q;
  logic             cpol_q;
  logic             cpha_q;

  logic             accept;
  logic             term;
  logic             last;
  logic [CNT_W:0]   edge_k;

  assign term   = (hcnt_q == div_q);
  assign edge_k = edge_q + (CNT_W+1)'(1);
  assign last   = (edge_k == {nbits_q, 1'b0});

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    edge_d   = edge_q;
    bidx_d   = bidx_q;
    sclk_d   = sclk_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;

    if (!bus.en_i) begin
      // Abort: drop to idle with the live idle level, bit index preserved.
      state_d = IDLE;
      sclk_d  = bus.cpol_i;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_d = bus.cpol_i;
          if (bus.start_i && (bus.nbits_i != '0)) begin
            accept  = 1'b1;
            state_d = RUN;
            hcnt_d  = '0;
            edge_d  = '0;
            bidx_d  = '0;
            // CPHA=0 must present the first MOSI bit before the leading edge.
            shift_d = ~bus.cpha_i;
          end
        end
        RUN: begin
          if (term) begin
            hcnt_d = '0;
            edge_d = edge_k;
            sclk_d = ~sclk_q;
            if (edge_k[0]) begin
              shift_d  = cpha_q;
              sample_d = ~cpha_q;
            end else begin
              shift_d  = ~cpha_q & ~last;
              sample_d = cpha_q;
            end
            if (edge_k[0] ^ cpha_q) bidx_d = bidx_q + CNT_W'(1);
            if (last) state_d = TAIL;
          end else begin
            hcnt_d = hcnt_q + DIV_W'(1);
          end
        end
        TAIL: begin
          if (term) begin
            hcnt_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      edge_q   <= '0;
      bidx_q   <= '0;
      sclk_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      edge_q   <= edge_d;
      bidx_q   <= bidx_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (accept) begin
      div_q   <= bus.div_i;
      nbits_q <= bus.nbits_i;
      cpol_q  <= bus.cpol_i;
      cpha_q  <= bus.cpha_i;
    end
  end

  assign bus.SCLK_o    = sclk_q;
  assign bus.shift_o   = shift_q;
  assign bus.sample_o  = sample_q;
  assign bus.bit_idx_o = bidx_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;

  // cpol_q is captured for completeness of the burst configuration; the idle
  // level after TAIL is already implied by the even number of toggles.
  logic unused_cpol;
  assign unused_cpol = cpol_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
module tb_spi_sclk_engine;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  spi_sclk_engine_if #(.DIV_W(8), .CNT_W(6)) bus ();

  spi_sclk_engine #(.DIV_W(8), .CNT_W(6)) u_dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Drives one burst starting at the current negedge and compares every cycle
  // against the closed-form expectation of the waveform. Returns when done_o
  // is due (at the negedge of that cycle).
  task automatic run_burst(input int dv, input int nb, input bit cp, input bit ch,
                           input bit mod,
                           output int nsh, output int nsa, output int ntog,
                           output int slast, output int werr, output int dcyc,
                           output int bend);
    int h, e2, t, k, e, eb;
    logic sh_e, sa_e, sclk_e, prev;
    h = dv + 1; e2 = 2 * nb; t = (e2 + 1) * h;
    nsh = 0; nsa = 0; ntog = 0; slast = 0; werr = 0; dcyc = -1;
    bus.en_i = 1'b1; bus.div_i = 8'(dv); bus.nbits_i = 6'(nb);
    bus.cpol_i = cp; bus.cpha_i = ch; bus.start_i = 1'b1;
    prev = cp;
    @(posedge clk);
    for (int j = 0; j <= t; j++) begin
      @(negedge clk);
      e = (j / h > e2) ? e2 : j / h;
      k = (j > 0 && (j % h) == 0 && (j / h) <= e2) ? j / h : 0;
      sclk_e = cp ^ e[0];
      if (ch) begin
        sh_e = (k % 2) == 1;
        sa_e = (k != 0) && ((k % 2) == 0);
        eb   = e / 2;
      end else begin
        sh_e = (j == 0) || ((k != 0) && ((k % 2) == 0) && (k < e2));
        sa_e = (k % 2) == 1;
        eb   = (e + 1) / 2;
      end
      if (bus.SCLK_o !== sclk_e) werr++;
      if (bus.shift_o !== sh_e) werr++;
      if (bus.sample_o !== sa_e) werr++;
      if (bus.busy_o !== (j < t)) werr++;
      if (bus.done_o !== (j == t)) werr++;
      if (bus.bit_idx_o !== 6'(eb)) werr++;
      if (bus.shift_o === 1'b1) nsh++;
      if (bus.sample_o === 1'b1) nsa++;
      if (bus.SCLK_o !== prev) ntog++;
      prev = bus.SCLK_o;
      if (k == e2 && bus.shift_o === 1'b1) slast++;
      if (bus.done_o === 1'b1 && dcyc < 0) dcyc = j;
      if (j == 0) bus.start_i = 1'b0;
      if (mod) begin
        if (j == 2) begin
          bus.div_i = ~8'(dv); bus.nbits_i = 6'd0; bus.cpol_i = ~cp;
          bus.cpha_i = ~ch; bus.start_i = 1'b1;
        end
        if (j == 3) bus.start_i = 1'b0;
        if (j == 5) bus.nbits_i = ~6'(nb);
        if (j == t) begin
          bus.div_i = 8'(dv); bus.nbits_i = 6'(nb); bus.cpol_i = cp; bus.cpha_i = ch;
        end
      end
    end
    bend = int'(bus.bit_idx_o);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; bus.en_i = 1'b1; bus.start_i = 1'b0; bus.cpol_i = 1'b1;
    bus.cpha_i = 1'b0; bus.div_i = 8'd0; bus.nbits_i = 6'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.SCLK_o !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", bus.SCLK_o); end
    n_checks++; if (bus.shift_o !== 1'b0) begin n_fail++; $display("FAIL reset_shift got %b want 0", bus.shift_o); end
    n_checks++; if (bus.sample_o !== 1'b0) begin n_fail++; $display("FAIL reset_sample got %b want 0", bus.sample_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    n_checks++; if (bus.bit_idx_o !== 6'd0) begin n_fail++; $display("FAIL reset_bidx got %0d want 0", bus.bit_idx_o); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.SCLK_o !== 1'b1) begin n_fail++; $display("FAIL idle_sclk_after_release got %b want 1", bus.SCLK_o); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.shift_o !== 1'b0 || bus.sample_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.done_o !== 1'b0 || bus.SCLK_o !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
    bus.cpol_i = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.SCLK_o !== 1'b0) begin n_fail++; $display("FAIL idle_follow_cpol got %b want 0", bus.SCLK_o); end
  endtask

  task automatic test_mode0();
    int nsh, nsa, ntog, sl, we, dc, be;
    run_burst(0, 1, 1'b0, 1'b0, 1'b0, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL mode0_wave got %0d errors want 0", we); end
    n_checks++; if (nsh !== 1 || nsa !== 1) begin n_fail++; $display("FAIL mode0_strobes got %0d/%0d want 1/1", nsh, nsa); end
    n_checks++; if (ntog !== 2) begin n_fail++; $display("FAIL mode0_toggles got %0d want 2", ntog); end
    n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL mode0_done got %0d want 3", dc); end
  endtask

  task automatic test_mode3();
    int nsh, nsa, ntog, sl, we, dc, be;
    run_burst(3, 8, 1'b1, 1'b1, 1'b0, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL mode3_wave got %0d errors want 0", we); end
    n_checks++; if (nsh !== 8 || nsa !== 8) begin n_fail++; $display("FAIL mode3_strobes got %0d/%0d want 8/8", nsh, nsa); end
    n_checks++; if (ntog !== 16) begin n_fail++; $display("FAIL mode3_toggles got %0d want 16", ntog); end
    n_checks++; if (be !== 8) begin n_fail++; $display("FAIL mode3_bidx got %0d want 8", be); end
    n_checks++; if (dc !== 68) begin n_fail++; $display("FAIL mode3_done got %0d want 68", dc); end
  endtask

  task automatic test_mode1_2();
    int nsh, nsa, ntog, sl, we, dc, be;
    for (int m = 1; m <= 2; m++) begin
      run_burst(1, 5, (m == 2), (m == 1), 1'b0, nsh, nsa, ntog, sl, we, dc, be);
      n_checks++; if (we !== 0) begin n_fail++; $display("FAIL mode%0d_wave got %0d errors want 0", m, we); end
      n_checks++; if (ntog !== 10) begin n_fail++; $display("FAIL mode%0d_toggles got %0d want 10", m, ntog); end
      n_checks++; if (nsh !== 5 || nsa !== 5) begin n_fail++; $display("FAIL mode%0d_strobes got %0d/%0d want 5/5", m, nsh, nsa); end
      n_checks++; if (sl !== 0) begin n_fail++; $display("FAIL mode%0d_last_shift got %0d want 0", m, sl); end
      n_checks++; if (dc !== 22) begin n_fail++; $display("FAIL mode%0d_done got %0d want 22", m, dc); end
    end
  endtask

  task automatic test_abort();
    int bad;
    bus.en_i = 1'b1; bus.div_i = 8'd3; bus.nbits_i = 6'd8;
    bus.cpol_i = 1'b1; bus.cpha_i = 1'b0; bus.start_i = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) bus.start_i = 1'b0;
      if (j == 19) bus.en_i = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy_o); end
    n_checks++; if (bus.SCLK_o !== 1'b1) begin n_fail++; $display("FAIL abort_sclk got %b want 1", bus.SCLK_o); end
    n_checks++; if (bus.sample_o !== 1'b0 || bus.shift_o !== 1'b0) begin n_fail++; $display("FAIL abort_strobes got %b%b want 00", bus.shift_o, bus.sample_o); end
    n_checks++; if (bus.bit_idx_o !== 6'd2) begin n_fail++; $display("FAIL abort_bidx got %0d want 2", bus.bit_idx_o); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d bad cycles want 0", bad); end
    bus.en_i = 1'b1; bus.nbits_i = 6'd0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy_o !== 1'b0 || bus.shift_o !== 1'b0 || bus.sample_o !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL zero_nbits_ignored got %0d bad cycles want 0", bad); end
    n_checks++; if (bus.bit_idx_o !== 6'd2) begin n_fail++; $display("FAIL zero_nbits_bidx got %0d want 2", bus.bit_idx_o); end
  endtask

  task automatic test_config_change();
    int nsh, nsa, ntog, sl, we, dc, be;
    run_burst(3, 4, 1'b0, 1'b1, 1'b1, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL cfgchg_wave got %0d errors want 0", we); end
    n_checks++; if (dc !== 36) begin n_fail++; $display("FAIL cfgchg_done got %0d want 36", dc); end
  endtask

  task automatic test_back_to_back();
    int nsh, nsa, ntog, sl, we, dc, be;
    run_burst(0, 2, 1'b0, 1'b1, 1'b0, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0 || dc !== 5) begin n_fail++; $display("FAIL b2b_first got err=%0d done=%0d want 0/5", we, dc); end
    run_burst(2, 3, 1'b1, 1'b0, 1'b1, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL b2b_second_wave got %0d errors want 0", we); end
    n_checks++; if (dc !== 21 || be !== 3) begin n_fail++; $display("FAIL b2b_second got done=%0d bidx=%0d want 21/3", dc, be); end
  endtask

  task automatic test_boundaries();
    int nsh, nsa, ntog, sl, we, dc, be;
    run_burst(255, 1, 1'b0, 1'b1, 1'b0, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL maxdiv_wave got %0d errors want 0", we); end
    n_checks++; if (dc !== 768 || ntog !== 2) begin n_fail++; $display("FAIL maxdiv got done=%0d tog=%0d want 768/2", dc, ntog); end
    run_burst(0, 63, 1'b1, 1'b0, 1'b0, nsh, nsa, ntog, sl, we, dc, be);
    n_checks++; if (we !== 0) begin n_fail++; $display("FAIL maxbits_wave got %0d errors want 0", we); end
    n_checks++; if (nsh !== 63 || nsa !== 63 || ntog !== 126) begin n_fail++; $display("FAIL maxbits_counts got %0d/%0d/%0d want 63/63/126", nsh, nsa, ntog); end
    n_checks++; if (be !== 63 || dc !== 127) begin n_fail++; $display("FAIL maxbits_end got bidx=%0d done=%0d want 63/127", be, dc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mode0();
    test_mode3();
    test_mode1_2();
    test_abort();
    test_config_change();
    test_back_to_back();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Programmable SPI serial-clock engine, successor to the fixed power-of-two SCLK divider. Runs bursts of a requested number of SCLK cycles at a runtime-selectable divisor, in any of the four CPOL/CPHA modes. Emits single-cycle shift/sample strobes that drive the MOSI shifter and MISO capture registers, plus a busy/done handshake to the transaction controller. Sits between the ADC/DAC transaction FSM and the SPI pad logic.

## Interface
- DIV_W, 8: width of divisor input; half-period H = div_i + 1 clocks (1..2^DIV_W).
- CNT_W, 6: width of bit-count input; bursts of 1..2^CNT_W-1 SCLK cycles.

- clock_i  input  1  system clock, 100 MHz; all logic on rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- en_i  input  1  block enable; low aborts any burst and holds idle.
- start_i  input  1  burst request, sampled in IDLE only.
- div_i  input  DIV_W  half-period minus one, latched at start accept.
- nbits_i  input  CNT_W  SCLK cycles per burst N, latched at start accept.
- cpol_i  input  1  idle clock level; latched at accept, followed live in IDLE.
- cpha_i  input  1  phase select, latched at accept.
- SCLK_o  output  1  serial clock, registered.
- shift_o  output  1  one-cycle strobe: present next MOSI bit.
- sample_o  output  1  one-cycle strobe: capture MISO.
- bit_idx_o  output  CNT_W  sample strobes issued in current burst.
- busy_o  output  1  high from accept until burst end.
- done_o  output  1  one-cycle pulse at normal burst completion.

## Operation
- States: IDLE, RUN, TAIL.
- IDLE: SCLK_o <= cpol_i each cycle; busy_o=0; strobes 0.
- Accept: rising edge (t=0) with state IDLE, en_i=1, start_i=1, nbits_i!=0. Latches div/nbits/cpol/cpha, clears half-period counter, edge counter, bit_idx_o; enters RUN. start_i with nbits_i=0, or while busy, is ignored.
- RUN: half-period counter (DIV_W bits) counts 0..div; on terminal count it wraps to 0 and edge k fires, k=1..2N (edge counter CNT_W+1 bits). Each edge toggles SCLK_o. Odd k = leading edge, even k = trailing edge.
- CPHA=0: shift_o in the cycle after t=0 (first-bit load) and at trailing edges k=2,4..2N-2; sample_o at odd k.
- CPHA=1: shift_o at odd k; sample_o at even k.
- Never a shift strobe on the final edge. bit_idx_o increments with each sample_o, reaching N.
- After edge 2N, enter TAIL: hold SCLK_o=CPOL for one more H, then IDLE with done_o pulse.
- en_i=0 in any state: next edge → IDLE, SCLK_o=cpol_i, busy_o=0, no done_o, no strobes, bit_idx_o held. Takes priority over all other events.
- Input changes while busy have no effect until next accept.

## Timing
- Reset (async assert): SCLK_o=0, shift_o=0, sample_o=0, busy_o=0, done_o=0, bit_idx_o=0, state IDLE. First cycle after release, SCLK_o follows cpol_i.
- busy_o high in the cycle after t=0.
- Edge k registered at t=k*H; SCLK_o change and its shift/sample strobe visible in the same cycle (cycle after t=k*H).
- TAIL ends at t=(2N+1)*H: busy_o falls and done_o pulses in the following cycle, together.
- Total busy duration (2N+1)*H cycles. Next accept possible on the edge after done_o.
- H=1 (div_i=0): SCLK period 2 clocks; strobes may be high on consecutive cycles. Each strobe stays exactly one cycle.
- div_i all-ones: H=2^DIV_W, counter wraps without overflow.
- nbits_i all-ones: 2*(2^CNT_W-1) edges, no counter overflow.

## Test plan
- Reset/idle: hold reset_ni=0, cpol_i=1 → all outputs 0; release → SCLK_o=1 next cycle, no strobes for 100 cycles with start_i=0.
- Mode 0, div_i=0, nbits_i=1, start at t=0 → shift at t=0+, SCLK rises at t=1 with sample, falls at t=2, done_o/busy_o fall at t=3+. Exactly 1 shift and 1 sample.
- Mode 3, div_i=3, nbits_i=8 → SCLK idles 1 with 8 low pulses of 4 clocks; shift at k=1,3..15 (8 strobes), sample at k=2..16 (8); bit_idx_o=8; done_o one cycle after t=68.
- Mode 1 and mode 2 sweep, div_i=1, nbits_i=5 → 10 SCLK toggles each; strobe counts 5/5; no shift on final edge.
- Abort: en_i dropped at t=20 during div_i=3, nbits_i=8 burst → busy_o=0 next cycle, SCLK_o=cpol_i, no done_o; start_i while busy and start_i with nbits_i=0 → ignored.
- Config change mid-burst: toggle div_i/cpol_i/nbits_i while busy → waveform identical to unmodified run; back-to-back start on edge after done_o → accepted.
